// File: rtl/filter_param_ctrl.sv
// SID filter register front end: shadow registers for $15-$18, committed
// to the live filter controls on sample ticks with fc/vol slew limiting.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   reg_we/addr/wdata register write port (0=FC_LO 1=FC_HI 2=RES_FILT 3=MODE_VOL)
//   sample_tick       1-cycle pulse aligned with filter sample_valid
//   fc,res,filt,mode,vol  live filter controls (registered)
//   busy              fc or vol still slewing toward target
//   commit            1-cycle pulse when any live output changed
module filter_param_ctrl #(
  parameter int FC_SLEW      = 16,
  parameter int VOL_SLEW_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        sample_tick,
  output logic [10:0] fc,
  output logic [3:0]  res,
  output logic [3:0]  filt,
  output logic [3:0]  mode,
  output logic [3:0]  vol,
  output logic        busy,
  output logic        commit
);

  typedef enum logic {
    SETTLED = 1'b0,
    SLEWING = 1'b1
  } state_t;

  localparam logic [11:0] SLEW   = 12'(FC_SLEW);
  localparam logic [10:0] STEP   = 11'(FC_SLEW);
  localparam logic [3:0]  VD_MAX = 4'(VOL_SLEW_DIV - 1);

  state_t      state;
  state_t      st_nx;

  logic [10:0] tgt_fc;
  logic [3:0]  sh_res;
  logic [3:0]  sh_filt;
  logic [3:0]  sh_mode;
  logic [3:0]  tgt_vol;
  logic [3:0]  vdiv;

  logic signed [11:0] d;
  logic [11:0] mag;
  logic [10:0] fc_nx;
  logic [3:0]  vol_nx;
  logic [3:0]  vdiv_nx;
  logic        changed;

  // Stepping toward an in-range target by at most |d| keeps fc in 0..2047.
  always_comb begin
    d     = $signed({1'b0, tgt_fc}) - $signed({1'b0, fc});
    mag   = d[11] ? 12'(-d) : 12'(d);
    fc_nx = tgt_fc;
    if (mag > SLEW) begin
      fc_nx = d[11] ? (fc - STEP) : (fc + STEP);
    end
  end

  // vdiv only counts while unsettled; vol moves one LSB per VOL_SLEW_DIV ticks.
  always_comb begin
    vol_nx  = vol;
    vdiv_nx = 4'd0;
    if (vol != tgt_vol) begin
      if (vdiv == VD_MAX) begin
        vol_nx = (vol > tgt_vol) ? (vol - 4'd1) : (vol + 4'd1);
      end else begin
        vdiv_nx = vdiv + 4'd1;
      end
    end
  end

  always_comb begin
    st_nx   = ((fc_nx != tgt_fc) || (vol_nx != tgt_vol)) ? SLEWING : SETTLED;
    changed = (fc_nx != fc) || (vol_nx != vol) ||
              (sh_res != res) || (sh_filt != filt) ||
              (sh_mode != mode);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SETTLED;
      tgt_fc  <= '0;
      sh_res  <= '0;
      sh_filt <= '0;
      sh_mode <= '0;
      tgt_vol <= '0;
      vdiv    <= '0;
      fc      <= '0;
      res     <= '0;
      filt    <= '0;
      mode    <= '0;
      vol     <= '0;
      busy    <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      // Tick reads the pre-write shadows; a same-edge write lands next tick.
      if (sample_tick) begin
        fc     <= fc_nx;
        vol    <= vol_nx;
        vdiv   <= vdiv_nx;
        res    <= sh_res;
        filt   <= sh_filt;
        mode   <= sh_mode;
        state  <= st_nx;
        busy   <= (st_nx == SLEWING);
        commit <= changed;
      end
      if (reg_we) begin
        unique case (reg_addr)
          2'd0: tgt_fc[2:0]  <= reg_wdata[2:0];
          2'd1: tgt_fc[10:3] <= reg_wdata;
          2'd2: begin
            sh_res  <= reg_wdata[7:4];
            sh_filt <= reg_wdata[3:0];
          end
          2'd3: begin
            sh_mode <= reg_wdata[7:4];
            tgt_vol <= reg_wdata[3:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_filter_param_ctrl.sv
// Bench for filter_param_ctrl: directed scenarios plus random traffic
// against an arithmetic reference model of the slew/commit rules.
module tb_filter_param_ctrl;

  localparam int SLEW = 16;
  localparam int VDIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        sample_tick;
  logic [10:0] fc;
  logic [3:0]  res, filt, mode, vol;
  logic        busy, commit;

  always #5 clk = ~clk;

  filter_param_ctrl #(.FC_SLEW(SLEW), .VOL_SLEW_DIV(VDIV)) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .sample_tick(sample_tick), .fc(fc),
    .res(res), .filt(filt), .mode(mode), .vol(vol),
    .busy(busy), .commit(commit)
  );

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  int m_tfc, m_sres, m_sfilt, m_smode, m_tvol;
  int m_fc, m_res, m_filt, m_mode, m_vol, m_busy, m_commit, m_vcnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".fc"},     int'(fc),     m_fc);
    chk({tag, ".res"},    int'(res),    m_res);
    chk({tag, ".filt"},   int'(filt),   m_filt);
    chk({tag, ".mode"},   int'(mode),   m_mode);
    chk({tag, ".vol"},    int'(vol),    m_vol);
    chk({tag, ".busy"},   int'(busy),   m_busy);
    chk({tag, ".commit"}, int'(commit), m_commit);
  endtask

  task automatic model_clear();
    m_tfc = 0; m_sres = 0; m_sfilt = 0; m_smode = 0; m_tvol = 0;
    m_fc = 0; m_res = 0; m_filt = 0; m_mode = 0; m_vol = 0;
    m_busy = 0; m_commit = 0; m_vcnt = 0;
  endtask

  task automatic model_edge(input bit rn, input bit we, input int a,
                            input int dat, input bit tk);
    int diff, nfc, nvol;
    if (!rn) begin
      model_clear();
      return;
    end
    m_commit = 0;
    if (tk) begin
      diff = m_tfc - m_fc;
      if (diff > SLEW)       nfc = m_fc + SLEW;
      else if (diff < -SLEW) nfc = m_fc - SLEW;
      else                   nfc = m_tfc;
      nvol = m_vol;
      if (m_vol != m_tvol) begin
        m_vcnt++;
        if (m_vcnt == VDIV) begin
          nvol   = (m_tvol > m_vol) ? m_vol + 1 : m_vol - 1;
          m_vcnt = 0;
        end
      end else begin
        m_vcnt = 0;
      end
      m_commit = (nfc != m_fc || nvol != m_vol || m_sres != m_res ||
                  m_sfilt != m_filt || m_smode != m_mode) ? 1 : 0;
      m_fc = nfc; m_vol = nvol;
      m_res = m_sres; m_filt = m_sfilt; m_mode = m_smode;
      m_busy = (m_fc != m_tfc || m_vol != m_tvol) ? 1 : 0;
    end
    if (we) begin
      case (a)
        0: m_tfc = (m_tfc & 12'h7F8) | (dat & 7);
        1: m_tfc = (m_tfc & 7) | (dat << 3);
        2: begin m_sres = dat >> 4; m_sfilt = dat & 15; end
        default: begin m_smode = dat >> 4; m_tvol = dat & 15; end
      endcase
    end
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input bit rn, input bit we, input int a,
                      input int dat, input bit tk, input string tag);
    rst_n       = rn;
    reg_we      = we;
    reg_addr    = 2'(a);
    reg_wdata   = 8'(dat);
    sample_tick = tk;
    @(posedge clk);
    model_edge(rn, we, a, dat, tk);
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic wr(input int a, input int dat);
    step(1'b1, 1'b1, a, dat, 1'b0, "wr");
  endtask

  task automatic tick(input string tag);
    step(1'b1, 1'b0, 0, 0, 1'b1, tag);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; sample_tick = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 0, 0, 1'b0, "reset0");
    step(1'b0, 1'b1, 1, 8'hFF, 1'b1, "reset1");
    chk("reset_fc", int'(fc), 0);
    chk("reset_busy", int'(busy), 0);

    // fc ramp to 2047
    wr(1, 8'hFF);
    wr(0, 8'h07);
    for (int i = 1; i <= 128; i++) begin
      tick("ramp");
      if (i == 1) begin
        chk("ramp_t1_fc", int'(fc), 16);
        chk("ramp_t1_busy", int'(busy), 1);
      end
      if (i == 127) chk("ramp_t127_fc", int'(fc), 2032);
      if (i == 128) begin
        chk("ramp_t128_fc", int'(fc), 2047);
        chk("ramp_t128_busy", int'(busy), 0);
      end
    end

    // shadow write without tick holds
    wr(2, 8'hA3);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 0, 0, 1'b0, "hold");
    end
    chk("hold_res", int'(res), 0);
    tick("rf_tick");
    chk("rf_res", int'(res), 10);
    chk("rf_filt", int'(filt), 3);
    chk("rf_commit", int'(commit), 1);
    step(1'b1, 1'b0, 0, 0, 1'b0, "rf_after");
    chk("rf_commit_drop", int'(commit), 0);

    // volume slew
    wr(3, 8'h1F);
    for (int i = 1; i <= 60; i++) begin
      tick("vol");
      if (i == 1) chk("vol_t1_mode", int'(mode), 1);
      if (i == 4) chk("vol_t4", int'(vol), 1);
      if (i == 8) chk("vol_t8", int'(vol), 2);
      if (i == 60) begin
        chk("vol_t60", int'(vol), 15);
        chk("vol_t60_busy", int'(busy), 0);
      end
    end
    tick("vol_idle");
    chk("vol_idle_commit", int'(commit), 0);

    // write coincident with tick
    step(1'b1, 1'b1, 3, 8'h20, 1'b1, "coinc");
    chk("coinc_mode0", int'(mode), 1);
    tick("coinc2");
    chk("coinc_mode1", int'(mode), 2);

    // fc down-slew from 512
    step(1'b0, 1'b0, 0, 0, 1'b0, "rst2");
    wr(1, 8'hFF);
    wr(0, 8'h07);
    for (int i = 0; i < 32; i++) tick("up512");
    chk("up512_fc", int'(fc), 512);
    wr(1, 8'h00);
    wr(0, 8'h00);
    for (int i = 1; i <= 32; i++) begin
      tick("down");
      if (i == 1) chk("down_t1", int'(fc), 496);
      if (i == 2) chk("down_t2", int'(fc), 480);
      if (i == 32) chk("down_t32", int'(fc), 0);
    end

    // reset mid-slew
    wr(1, 8'h40);
    wr(3, 8'h5C);
    for (int i = 0; i < 6; i++) tick("preslew");
    step(1'b0, 1'b1, 1, 8'hFF, 1'b1, "midrst0");
    step(1'b0, 1'b1, 3, 8'hFF, 1'b1, "midrst1");
    chk("midrst_fc", int'(fc), 0);
    for (int i = 0; i < 5; i++) tick("postrst");
    chk("postrst_fc", int'(fc), 0);
    chk("postrst_commit", int'(commit), 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 1) == 1), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
